// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types, widths and helpers for the fetch sequencer
package fetch_seq_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory and decode handshake bundle
interface fetch_sequencer_if;
  import fetch_seq_pkg::*;

  logic               imemReq;
  logic [31:0]        imemAddr;
  logic               imemAck;
  logic [INSTR_W-1:0] imemData;
  logic [INSTR_W-1:0] instr;
  logic               instrValid;
  logic               instrReady;
  logic               branch;
  logic               jump;
  logic               jumpR;
  logic               zero;
  logic [31:0]        Da;

  modport master (
    output imemReq, imemAddr, instr, instrValid,
    input  imemAck, imemData, instrReady, branch, jump, jumpR, zero, Da
  );

  modport slave (
    input  imemReq, imemAddr, instr, instrValid,
    output imemAck, imemData, instrReady, branch, jump, jumpR, zero, Da
  );

endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next word PC: jumpR > jump > taken branch > sequential
module next_pc_calc
  import fetch_seq_pkg::*;
(
  input  logic [PC_W-1:0]    pc,
  input  logic [JADDR_W-1:0] jaddr,
  input  logic [PC_W-1:0]    da_word,
  input  logic               branch,
  input  logic               jump,
  input  logic               jumpR,
  input  logic               zero,
  output logic [PC_W-1:0]    next_pc
);

  logic [PC_W-1:0] seq_pc;

  // All arithmetic is 30-bit, so wrap past the top of the address space is silent
  assign seq_pc = pc + PC_W'(1);

  always_comb begin
    next_pc = seq_pc;
    if (jumpR) begin
      next_pc = da_word;
    end else if (jump) begin
      next_pc = {pc[PC_W-1:JADDR_W], jaddr};
    end else if (branch && !zero) begin
      next_pc = seq_pc + sext_imm(jaddr[IMM_W-1:0]);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch FSM; FETCH_TIMEOUT_EN adds a memory-wait watchdog
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC       = 30'h0000_0000,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  fetch_sequencer_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic            fault
);

  fetch_state_t       state, state_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    next_pc;
  logic               timeout;

  next_pc_calc u_next_pc (
    .pc      (pc),
    .jaddr   (instr_q[JADDR_W-1:0]),
    .da_word (bus.Da[31:2]),
    .branch  (bus.branch),
    .jump    (bus.jump),
    .jumpR   (bus.jumpR),
    .zero    (bus.zero),
    .next_pc (next_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counter sits at zero outside FETCH, so every entry into FETCH starts from zero
  always_ff @(posedge clk) begin
    if (reset || state != FETCH || bus.imemAck) begin
      wait_cnt <= '0;
    end else if (!timeout) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = (state == FETCH) && !bus.imemAck && (wait_cnt >= CNT_LAST);
  assign fault   = (state == HALT);
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && bus.imemAck) begin
        instr_q <= bus.imemData;
      end
      if (state == ISSUE && bus.instrReady) begin
        pc <= next_pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (bus.imemAck) begin
          state_nxt = ISSUE;
        end else if (timeout) begin
          state_nxt = HALT;
        end
      end
      ISSUE: begin
        if (bus.instrReady) begin
          state_nxt = FETCH;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Handshake outputs decode the state register only; no input reaches them combinationally
  assign bus.imemReq    = (state == FETCH);
  assign bus.imemAddr   = {pc, 2'b00};
  assign bus.instr      = instr_q;
  assign bus.instrValid = (state == ISSUE);

endmodule
